// File: rtl/demux_a_unpack_if.sv
// Handshake bundle for demux_a_unpack: 2*DATA_W word side, DATA_W beat side, debug status.
// Optional out_par exists only when DEMUX_A_UNPACK_PARITY_EN is defined.
interface demux_a_unpack_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2*DATA_W-1:0]   in_data;
  logic                  sel;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_data;
  logic                  out_last;
  logic                  busy;
  logic [CNT_W-1:0]      words_done;
`ifdef DEMUX_A_UNPACK_PARITY_EN
  logic                  out_par;
`endif

  modport master (
    output in_valid, in_data, sel, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, words_done
`ifdef DEMUX_A_UNPACK_PARITY_EN
    , input out_par
`endif
  );

  modport slave (
    input  in_valid, in_data, sel, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, words_done
`ifdef DEMUX_A_UNPACK_PARITY_EN
    , output out_par
`endif
  );
endinterface

// File: rtl/demux_a_unpack.sv
// Splits a 2*DATA_W word into one (sel=0, low half) or two DATA_W beats; 1-cycle registered latency,
// stalls hold the beat while out_ready=0, last beat may overlap the next accept. Macro DEMUX_A_UNPACK_PARITY_EN adds out_par.
module demux_a_unpack #(
  parameter int DATA_W    = 16,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  demux_a_unpack_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FIRST = 2'd1, S_SECOND = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2*DATA_W-1:0]   r_word;
  logic                  r_sel;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [DATA_W-1:0]     r_out_data;
  logic [CNT_W-1:0]      r_words_done;

  logic                  w_out_hs;
  logic                  w_word_done;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_beat_load;
  logic [DATA_W-1:0]     w_beat_nxt;
  logic                  w_last_nxt;

  assign w_out_hs    = r_out_valid & bus.out_ready;
  assign w_word_done = w_out_hs & r_out_last;
  // A new word may load in the same cycle the last beat of the current one leaves.
  assign w_in_ready  = (r_state == S_IDLE) | w_word_done;
  assign w_accept    = bus.in_valid & w_in_ready;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_FIRST;
      S_FIRST:  if (w_out_hs) begin
                  if (r_sel)         w_state_nxt = S_SECOND;
                  else if (w_accept) w_state_nxt = S_FIRST;
                  else               w_state_nxt = S_IDLE;
                end
      S_SECOND: if (w_out_hs) w_state_nxt = w_accept ? S_FIRST : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_beat_load = 1'b0;
    w_beat_nxt  = r_out_data;
    w_last_nxt  = r_out_last;
    if (w_accept) begin
      w_beat_load = 1'b1;
      w_beat_nxt  = (bus.sel && !LSB_FIRST) ? bus.in_data[2*DATA_W-1:DATA_W]
                                            : bus.in_data[DATA_W-1:0];
      w_last_nxt  = ~bus.sel;
    end else if ((r_state == S_FIRST) && r_sel && w_out_hs) begin
      w_beat_load = 1'b1;
      w_beat_nxt  = LSB_FIRST ? r_word[2*DATA_W-1:DATA_W] : r_word[DATA_W-1:0];
      w_last_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_word       <= '0;
      r_sel        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_data   <= '0;
      r_words_done <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != S_IDLE);
      if (w_accept) begin
        r_word <= bus.in_data;
        r_sel  <= bus.sel;
      end
      if (w_beat_load) begin
        r_out_data <= w_beat_nxt;
        r_out_last <= w_last_nxt;
      end
      if (w_word_done) r_words_done <= r_words_done + CNT_ONE;
    end
  end

`ifdef DEMUX_A_UNPACK_PARITY_EN
  logic r_out_par;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_out_par <= 1'b0;
    else if (w_beat_load) r_out_par <= ^w_beat_nxt;
  end
  assign bus.out_par = r_out_par;
`endif

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_last   = r_out_last;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.words_done = r_words_done;
endmodule

// File: tb/tb_demux_a_unpack.sv
// Bench for demux_a_unpack: two instances (LSB-first/CNT_W=8 and MSB-first/CNT_W=2) driven in lockstep,
// directed scenarios plus randomized traffic against a beat-queue reference model.
module tb_demux_a_unpack;
  typedef struct packed {
    logic [15:0] da;
    logic [15:0] db;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tb_in_valid = 1'b0;
  logic        tb_sel = 1'b0;
  logic        tb_out_ready = 1'b0;
  logic [31:0] tb_in_data = 32'h0;

  int    checks = 0;
  int    errors = 0;
  int    mcnt = 0;
  beat_t mq[$];

  always #5 clk = ~clk;

  demux_a_unpack_if #(.DATA_W(16), .CNT_W(8)) ia ();
  demux_a_unpack_if #(.DATA_W(16), .CNT_W(2)) ib ();

  assign ia.in_valid  = tb_in_valid;
  assign ia.in_data   = tb_in_data;
  assign ia.sel       = tb_sel;
  assign ia.out_ready = tb_out_ready;
  assign ib.in_valid  = tb_in_valid;
  assign ib.in_data   = tb_in_data;
  assign ib.sel       = tb_sel;
  assign ib.out_ready = tb_out_ready;

  demux_a_unpack #(.DATA_W(16), .LSB_FIRST(1'b1), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  demux_a_unpack #(.DATA_W(16), .LSB_FIRST(1'b0), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  // Advance one clock and update the reference model from the inputs held across that edge.
  task automatic tick();
    bit hs, rdy;
    @(posedge clk);
    if (rst_n) begin
      hs  = (mq.size() != 0) && tb_out_ready;
      rdy = (mq.size() == 0) || ((mq.size() == 1) && tb_out_ready);
      if (hs) begin
        if (mq.size() == 1) mcnt++;
        mq.delete(0);
      end
      if (tb_in_valid && rdy) begin
        if (!tb_sel) begin
          mq.push_back('{da: tb_in_data[15:0], db: tb_in_data[15:0], last: 1'b1});
        end else begin
          mq.push_back('{da: tb_in_data[15:0], db: tb_in_data[31:16], last: 1'b0});
          mq.push_back('{da: tb_in_data[31:16], db: tb_in_data[15:0], last: 1'b1});
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (ia.out_valid !== 1'b0 || ia.out_data !== 16'h0 || ia.busy !== 1'b0 || ia.words_done !== 8'h0)
      begin errors++; $display("FAIL reset_hold got vld=%b dat=%h busy=%b wd=%h exp 0", ia.out_valid, ia.out_data, ia.busy, ia.words_done); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ia.in_ready !== 1'b1 || ib.in_ready !== 1'b1)
      begin errors++; $display("FAIL reset_in_ready got a=%b b=%b exp 1", ia.in_ready, ib.in_ready); end
    checks++;
    if (ia.out_valid !== 1'b0 || ia.out_data !== 16'h0 || ia.out_last !== 1'b0 || ia.busy !== 1'b0)
      begin errors++; $display("FAIL reset_outputs got vld=%b dat=%h last=%b busy=%b exp 0", ia.out_valid, ia.out_data, ia.out_last, ia.busy); end
    checks++;
    if (ia.words_done !== 8'h0 || ib.words_done !== 2'h0)
      begin errors++; $display("FAIL reset_count got a=%h b=%h exp 0", ia.words_done, ib.words_done); end
  endtask

  task automatic test_single();
    tb_out_ready = 1'b1; tb_sel = 1'b0; tb_in_data = 32'hA5A5A5A5; tb_in_valid = 1'b1;
    tick();
    tb_in_valid = 1'b0; tb_in_data = 32'h0;
    #1;
    checks++;
    if (ia.out_valid !== 1'b1 || ia.out_data !== 16'hA5A5 || ia.out_last !== 1'b1 || ib.out_data !== 16'hA5A5)
      begin errors++; $display("FAIL single_beat got vld=%b a=%h b=%h last=%b exp 1 A5A5 A5A5 1", ia.out_valid, ia.out_data, ib.out_data, ia.out_last); end
    tick();
    checks++;
    if (ia.out_valid !== 1'b0 || ia.busy !== 1'b0 || ia.words_done !== 8'd1 || ib.words_done !== 2'd1)
      begin errors++; $display("FAIL single_done got vld=%b busy=%b wda=%0d wdb=%0d exp 0 0 1 1", ia.out_valid, ia.busy, ia.words_done, ib.words_done); end
  endtask

  task automatic test_two_beat();
    tb_out_ready = 1'b1; tb_sel = 1'b1; tb_in_data = 32'hB6B61234; tb_in_valid = 1'b1;
    tick();
    tb_in_valid = 1'b0;
    #1;
    checks++;
    if (ia.out_valid !== 1'b1 || ia.out_data !== 16'h1234 || ia.out_last !== 1'b0 || ib.out_data !== 16'hB6B6 || ib.out_last !== 1'b0)
      begin errors++; $display("FAIL two_beat_first got a=%h/%b b=%h/%b exp 1234/0 B6B6/0", ia.out_data, ia.out_last, ib.out_data, ib.out_last); end
    tick();
    checks++;
    if (ia.out_valid !== 1'b1 || ia.out_data !== 16'hB6B6 || ia.out_last !== 1'b1 || ib.out_data !== 16'h1234 || ib.out_last !== 1'b1)
      begin errors++; $display("FAIL two_beat_second got a=%h/%b b=%h/%b exp B6B6/1 1234/1", ia.out_data, ia.out_last, ib.out_data, ib.out_last); end
    tick();
    checks++;
    if (ia.out_valid !== 1'b0 || ia.words_done !== 8'd2 || ib.words_done !== 2'd2)
      begin errors++; $display("FAIL two_beat_done got vld=%b wda=%0d wdb=%0d exp 0 2 2", ia.out_valid, ia.words_done, ib.words_done); end
  endtask

  task automatic test_back_to_back();
    tb_out_ready = 1'b1; tb_sel = 1'b1; tb_in_data = 32'hC7C7ABCD; tb_in_valid = 1'b1;
    tick();
    tb_sel = 1'b0; tb_in_data = 32'h00005678;
    #1;
    checks++;
    if (ia.out_data !== 16'hABCD || ib.out_data !== 16'hC7C7 || ia.out_last !== 1'b0 || ia.in_ready !== 1'b0)
      begin errors++; $display("FAIL b2b_beat0 got a=%h b=%h last=%b rdy=%b exp ABCD C7C7 0 0", ia.out_data, ib.out_data, ia.out_last, ia.in_ready); end
    tick();
    checks++;
    if (ia.out_valid !== 1'b1 || ia.out_data !== 16'hC7C7 || ib.out_data !== 16'hABCD || ia.out_last !== 1'b1 || ia.in_ready !== 1'b1)
      begin errors++; $display("FAIL b2b_beat1 got vld=%b a=%h b=%h last=%b rdy=%b exp 1 C7C7 ABCD 1 1", ia.out_valid, ia.out_data, ib.out_data, ia.out_last, ia.in_ready); end
    tick();
    tb_in_valid = 1'b0;
    checks++;
    if (ia.out_valid !== 1'b1 || ia.out_data !== 16'h5678 || ib.out_data !== 16'h5678 || ia.out_last !== 1'b1)
      begin errors++; $display("FAIL b2b_beat2 got vld=%b a=%h b=%h last=%b exp 1 5678 5678 1", ia.out_valid, ia.out_data, ib.out_data, ia.out_last); end
    tick();
    checks++;
    if (ia.out_valid !== 1'b0 || ia.words_done !== 8'd4 || ib.words_done !== 2'd0)
      begin errors++; $display("FAIL b2b_done got vld=%b wda=%0d wdb=%0d exp 0 4 0", ia.out_valid, ia.words_done, ib.words_done); end
  endtask

  task automatic test_stall();
    tb_out_ready = 1'b0; tb_sel = 1'b1; tb_in_data = 32'h11112222; tb_in_valid = 1'b1;
    tick();
    tb_sel = 1'b0; tb_in_data = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ia.out_valid !== 1'b1 || ia.out_data !== 16'h2222 || ia.out_last !== 1'b0 || ia.in_ready !== 1'b0 || ib.out_data !== 16'h1111)
        begin errors++; $display("FAIL stall_hold[%0d] got vld=%b a=%h last=%b rdy=%b b=%h exp 1 2222 0 0 1111", i, ia.out_valid, ia.out_data, ia.out_last, ia.in_ready, ib.out_data); end
      tick();
    end
    tb_in_valid = 1'b0; tb_out_ready = 1'b1;
    #1;
    checks++;
    if (ia.out_data !== 16'h2222 || ia.out_last !== 1'b0)
      begin errors++; $display("FAIL stall_release got a=%h last=%b exp 2222 0", ia.out_data, ia.out_last); end
    tick();
    checks++;
    if (ia.out_data !== 16'h1111 || ia.out_last !== 1'b1 || ib.out_data !== 16'h2222)
      begin errors++; $display("FAIL stall_second got a=%h last=%b b=%h exp 1111 1 2222", ia.out_data, ia.out_last, ib.out_data); end
    tick();
    checks++;
    if (ia.out_valid !== 1'b0 || ia.words_done !== 8'd5)
      begin errors++; $display("FAIL stall_done got vld=%b wd=%0d exp 0 5", ia.out_valid, ia.words_done); end
    tb_sel = 1'b1; tb_in_data = 32'h11112222; tb_in_valid = 1'b1;
    tick();
    tb_in_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    mcnt = 0;
    checks++;
    if (ia.out_valid !== 1'b0 || ia.out_data !== 16'h0 || ia.out_last !== 1'b0 || ia.busy !== 1'b0 || ia.words_done !== 8'h0 || ib.words_done !== 2'h0)
      begin errors++; $display("FAIL reset_midword got vld=%b dat=%h last=%b busy=%b wda=%h wdb=%h exp all 0", ia.out_valid, ia.out_data, ia.out_last, ia.busy, ia.words_done, ib.words_done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    logic [1:0]  wrap_exp [5];
    logic [31:0] w;
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    tb_out_ready = 1'b1; tb_sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w = (i == 0) ? 32'h00000007 : (i == 1) ? 32'h00000003 : $urandom;
      tb_in_data = w; tb_in_valid = 1'b1;
      tick();
      tb_in_valid = 1'b0;
      checks++;
      if (ia.out_valid !== 1'b1 || ia.out_data !== w[15:0] || ib.out_data !== w[15:0])
        begin errors++; $display("FAIL wrap_beat[%0d] got vld=%b a=%h b=%h exp 1 %h", i, ia.out_valid, ia.out_data, ib.out_data, w[15:0]); end
`ifdef DEMUX_A_UNPACK_PARITY_EN
      checks++;
      if (ia.out_par !== ((i == 0) ? 1'b1 : (i == 1) ? 1'b0 : ^w[15:0]))
        begin errors++; $display("FAIL wrap_parity[%0d] got %b for beat %h", i, ia.out_par, ia.out_data); end
`endif
      tick();
      checks++;
      if (ib.words_done !== wrap_exp[i])
        begin errors++; $display("FAIL wrap_count[%0d] got %0d exp %0d", i, ib.words_done, wrap_exp[i]); end
    end
  endtask

  task automatic test_random();
    bit m_vld, m_rdy;
    for (int c = 0; c < 400; c++) begin
      tb_in_valid  = ($urandom_range(0, 2) != 0);
      tb_sel       = $urandom_range(0, 1) == 1;
      tb_in_data   = $urandom;
      tb_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      m_vld = (mq.size() != 0);
      m_rdy = (mq.size() == 0) || ((mq.size() == 1) && tb_out_ready);
      checks++;
      if (ia.in_ready !== m_rdy || ib.in_ready !== m_rdy)
        begin errors++; $display("FAIL rnd_in_ready cyc=%0d got a=%b b=%b exp %b", c, ia.in_ready, ib.in_ready, m_rdy); end
      checks++;
      if (ia.out_valid !== m_vld || ib.out_valid !== m_vld || ia.busy !== m_vld || ib.busy !== m_vld)
        begin errors++; $display("FAIL rnd_valid cyc=%0d got vld=%b/%b busy=%b/%b exp %b", c, ia.out_valid, ib.out_valid, ia.busy, ib.busy, m_vld); end
      if (m_vld) begin
        checks++;
        if (ia.out_data !== mq[0].da || ia.out_last !== mq[0].last || ib.out_data !== mq[0].db || ib.out_last !== mq[0].last)
          begin errors++; $display("FAIL rnd_beat cyc=%0d got a=%h/%b b=%h/%b exp %h/%b %h/%b", c, ia.out_data, ia.out_last, ib.out_data, ib.out_last, mq[0].da, mq[0].last, mq[0].db, mq[0].last); end
`ifdef DEMUX_A_UNPACK_PARITY_EN
        checks++;
        if (ia.out_par !== ^mq[0].da || ib.out_par !== ^mq[0].db)
          begin errors++; $display("FAIL rnd_parity cyc=%0d got a=%b b=%b", c, ia.out_par, ib.out_par); end
`endif
      end
      checks++;
      if (ia.words_done !== 8'(mcnt) || ib.words_done !== 2'(mcnt))
        begin errors++; $display("FAIL rnd_count cyc=%0d got a=%0d b=%0d exp %0d/%0d", c, ia.words_done, ib.words_done, 8'(mcnt), 2'(mcnt)); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_beat();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux_a_unpack.md
Name: demux_a_unpack

Overview:
- Reverse of the operand-A widening path: takes a 32-bit datapath word and emits it as 16-bit beats onto the 16-bit side of the RISC core, for writeback and data-memory stores.
- `sel` picks the mode per word: a single truncated beat, or two beats carrying the full word.
- Valid/ready handshake on both sides, registered output, back-to-back words without bubbles.
- A wrapping completed-word counter supports debug.

Parameters:
- DATA_W, 16, output beat width; the input word is 2*DATA_W bits wide.
- LSB_FIRST, 1, 1: low half goes out first in two-beat mode; 0: high half goes out first.
- CNT_W, 8, width of the completed-word counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  2*DATA_W  word to unpack.
- sel  input  1  sampled with in_data: 1 = two beats (full word), 0 = one beat (low half only).
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_W  current beat.
- out_last  output  1  current beat is the final beat of its word.
- busy  output  1  a word is held (state != IDLE).
- words_done  output  CNT_W  count of completed words, wraps at 2^CNT_W.

Behaviour:
- States: IDLE, FIRST, SECOND. Encoding is free; SECOND is reachable only when the captured sel is 1.
- Reset (rst_n low, async): state=IDLE, out_valid=0, out_data=0, out_last=0, busy=0, words_done=0, internal word/sel registers=0. in_ready=1 once rst_n is high.
- in_ready is combinational: 1 when state=IDLE, or when the current beat is out_last and out_valid & out_ready. This allows a new word to load in the same cycle the last beat leaves.
- Accept occurs when in_valid & in_ready. The next cycle has state=FIRST, out_valid=1, and latency is 1 cycle. in_data and sel are captured into internal registers.
- FIRST, captured sel=0:
  - out_data = word[DATA_W-1:0], out_last=1.
- FIRST, captured sel=1:
  - out_data = low half if LSB_FIRST=1, else high half; out_last=0.
  - On handshake, go to SECOND.
- SECOND:
  - out_data = the other half, out_last=1.
- Any beat with out_last=1 completes the word on handshake:
  - words_done increments by 1, and 2^CNT_W-1 wraps to 0.
  - If a new word is accepted in the same cycle, go to FIRST with the new data; otherwise go to IDLE with out_valid=0.
- Stall: while out_valid & !out_ready, out_data, out_last and state hold stable. in_ready=0 unless idle.
- in_data/sel changes are ignored while not accepting; sel is only meaningful on the accept cycle.
- out_data holds its last value in IDLE. Benches must not check out_data when out_valid=0.
- out_valid never drops without a handshake, except on reset.
- Reset mid-word: the word is discarded, outputs return to reset values immediately, and no partial count occurs.
- busy = (state != IDLE).

Optional Feature:
- Macro DEMUX_A_UNPACK_PARITY_EN.
- When defined, the block adds output port out_par (1 bit) = even parity (XOR reduction) of out_data. out_par is registered with out_data, is 0 on reset, and holds during stalls.
- When undefined, the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, then rst_n high -> in_ready=1, out_valid=0, out_data=0000, words_done=00, busy=0.
- sel=0, in_data=A5A5A5A5, out_ready=1 -> one cycle later a single beat A5A5 with out_last=1; words_done=01; back to IDLE.
- sel=1, in_data=B6B61234, out_ready=1, LSB_FIRST=1 -> beats 1234 (last=0) then B6B6 (last=1), consecutive cycles; with LSB_FIRST=0 the order is B6B6 then 1234.
- Back-to-back: sel=1 C7C7ABCD then sel=0 00005678, in_valid held, out_ready=1 -> ABCD, C7C7, 5678 on three consecutive cycles with no bubble; words_done increments by 2.
- Stall: two-beat word 11112222 with out_ready=0 for 4 cycles at FIRST -> 2222 held stable with in_ready=0. Release -> 2222, 1111. Assert rst_n low during SECOND of a repeat -> outputs drop to reset values asynchronously and words_done=0.
- Wrap and parity: CNT_W=2, issue 5 single-beat words -> words_done goes 1,2,3,0,1. With DEMUX_A_UNPACK_PARITY_EN, beat 0007 -> out_par=1, beat 0003 -> out_par=0.
